execute_muldiv: RTL

Execute-stage pipeline register with an integrated iterative RV64M multiply/divide unit. Sits directly upstream of the memory stage: it consumes decoded instructions plus the combinational ALU result and produces `excute_data_t dataE`. Single-cycle ops pass through in one cycle; M-extension ops hold the stage in a shift-add / restoring-division FSM until the result is ready. Upstream and downstream back-pressure are both honoured.

---
 rtl/execute_muldiv.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv.sv
// -----------------------------------------------------------------------------
// execute_muldiv
//   Execute-stage pipeline register with an iterative RV64M multiply/divide
//   unit. Single-cycle ops take alu_result straight into dataE. M-extension
//   ops hold the stage in a shift-add (MUL*) or restoring-division (DIV/REM)
//   loop. The loop runs one bit per cycle on operand magnitudes. The sign fix
//   is applied when the result is written out.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-low reset
//   dataD       in   decoded instruction (decode_data_t)
//   alu_result  in   combinational ALU result for dataD (non-M ops)
//   src2        in   second operand after the immediate mux (M ops)
//   stopm       in   memory-stage stall; dataE and the FSM hold while high
//   flushall    in   synchronous kill of in-flight work
//   dataE       out  registered stage output (excute_data_t)
//   stope       out  stall request to decode; dataD must be held while high
//   dbg_state   out  FSM state (0 IDLE, 1 MUL_RUN, 2 DIV_RUN, 3 DONE)
//   dbg_count   out  iteration counter
//
// Flow control: dataD is consumed at a rising edge when dataD.valid=1,
// stope=0 and stopm=0. dataE is consumed by the memory stage at any rising
// edge with stopm=0. It stays constant across every edge where stopm=1.
// An M op keeps stope high until the edge that writes its result. Decode
// must present the next instruction after that edge.
// -----------------------------------------------------------------------------
package execute_muldiv_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [15:0] ctl;
    logic [4:0]  dst;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [11:0] csrdst;
    logic [63:0] csr;
    logic        error;
  } decode_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [15:0] ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] rd2;
    logic [11:0] csrdst;
    logic [63:0] csr;
    logic        error;
  } excute_data_t;

endpackage

module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  decode_data_t dataD,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] src2,
  input  logic         stopm,
  input  logic         flushall,
  output excute_data_t dataE,
  output logic         stope,
  output logic [1:0]   dbg_state,
  output logic [6:0]   dbg_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t       state_q;
  logic [6:0]   cnt_q;
  excute_data_t dataE_q;

  // Iteration datapath registers
  logic [127:0] acc_q;       // multiply accumulator
  logic [127:0] mcand_q;     // multiplicand, shifts left each cycle
  logic [63:0]  mplier_q;    // multiplier, shifts right each cycle
  logic [63:0]  rem_q;       // partial remainder
  logic [63:0]  quo_q;       // dividend bits in, quotient bits out
  logic [63:0]  dvs_q;       // divisor magnitude
  logic [2:0]   op_q;        // funct3 of the running op
  logic         is_w_q;
  logic         neg_q;       // negate the magnitude result on exit
  logic         special_q;   // divide-by-zero or signed overflow
  logic [63:0]  special_res_q;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic        is_op, is_op32, m_op, is_div;
  logic [2:0]  f3;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        div_zero, div_ovf, res_neg;
  logic [63:0] special_res;

  always_comb begin
    is_op    = (dataD.instr[6:0] == 7'b0110011);
    is_op32  = (dataD.instr[6:0] == 7'b0111011);
    m_op     = dataD.valid & (is_op | is_op32) & (dataD.instr[31:25] == 7'b0000001);
    f3       = dataD.instr[14:12];
    is_div   = f3[2];

    // MUL/MULW only need the low half, so they run unsigned.
    a_signed = is_div ? ~f3[0] : ((f3 == 3'b001) | (f3 == 3'b010));
    b_signed = is_div ? ~f3[0] : (f3 == 3'b001);

    if (is_op32) begin
      a_ext = a_signed ? {{32{dataD.rd1[31]}}, dataD.rd1[31:0]} : {32'b0, dataD.rd1[31:0]};
      b_ext = b_signed ? {{32{src2[31]}}, src2[31:0]} : {32'b0, src2[31:0]};
    end else begin
      a_ext = dataD.rd1;
      b_ext = src2;
    end

    a_neg = a_signed & a_ext[63];
    b_neg = b_signed & b_ext[63];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;

    // A remainder takes the dividend's sign; every other result takes the
    // xor of both operand signs.
    res_neg = (is_div & f3[1]) ? a_neg : (a_neg ^ b_neg);

    div_zero = (b_ext == 64'd0);
    div_ovf  = a_signed & (b_ext == {64{1'b1}}) &
               (is_op32 ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                        : (a_ext == 64'h8000_0000_0000_0000));

    special_res = 64'd0;
    if (div_zero) begin
      if (f3[1]) special_res = is_op32 ? {{32{dataD.rd1[31]}}, dataD.rd1[31:0]} : dataD.rd1;
      else       special_res = {64{1'b1}};
    end else if (div_ovf) begin
      special_res = f3[1] ? 64'd0 : a_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step of each loop
  // ---------------------------------------------------------------------------
  logic [127:0] acc_step;
  logic [64:0]  div_tmp;
  logic         div_ge;
  logic [63:0]  rem_step, quo_step;
  logic         last_iter;

  always_comb begin
    acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    div_tmp   = {rem_q, quo_q[63]};
    div_ge    = div_tmp[64] | (div_tmp[63:0] >= dvs_q);
    rem_step  = div_ge ? (div_tmp[63:0] - dvs_q) : div_tmp[63:0];
    quo_step  = {quo_q[62:0], div_ge};
    last_iter = (cnt_q == (is_w_q ? 7'd31 : 7'd63));
  end

  // ---------------------------------------------------------------------------
  // Result formation on exit from DONE
  // ---------------------------------------------------------------------------
  logic [127:0] prod_fix;
  logic [63:0]  mul_res, quo_fix, rem_fix, div_raw, div_res, m_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    if ((op_q[1:0] != 2'b00) && !is_w_q) mul_res = prod_fix[127:64];
    else if (is_w_q)                     mul_res = {{32{prod_fix[31]}}, prod_fix[31:0]};
    else                                 mul_res = prod_fix[63:0];

    quo_fix = neg_q ? -quo_q : quo_q;
    rem_fix = neg_q ? -rem_q : rem_q;
    div_raw = op_q[1] ? rem_fix : quo_fix;
    if (special_q)   div_res = special_res_q;
    else if (is_w_q) div_res = {{32{div_raw[31]}}, div_raw[31:0]};
    else             div_res = div_raw;

    m_res = op_q[2] ? div_res : mul_res;
  end

  function automatic excute_data_t stage_out(input decode_data_t d,
                                             input logic [63:0] res,
                                             input logic        v);
    excute_data_t o;
    o.valid  = v;
    o.pc     = d.pc;
    o.instr  = d.instr;
    o.ctl    = d.ctl;
    o.dst    = d.dst;
    o.result = res;
    o.rd2    = d.rd2;
    o.csrdst = d.csrdst;
    o.csr    = d.csr;
    o.error  = d.error;
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM and stage register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      dataE_q       <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      op_q          <= '0;
      is_w_q        <= 1'b0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
    end else if (flushall) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      dataE_q.valid <= 1'b0;
    end else if (!stopm) begin
      unique case (state_q)
        S_IDLE: begin
          if (m_op) begin
            state_q       <= is_div ? S_DIV_RUN : S_MUL_RUN;
            cnt_q         <= 7'd0;
            acc_q         <= '0;
            mcand_q       <= {64'd0, a_mag};
            mplier_q      <= b_mag;
            rem_q         <= '0;
            // W divides left-align the 32-bit dividend so the quotient ends
            // up in the low half after 32 shifts.
            quo_q         <= is_op32 ? {a_mag[31:0], 32'd0} : a_mag;
            dvs_q         <= b_mag;
            op_q          <= f3;
            is_w_q        <= is_op32;
            neg_q         <= res_neg;
            special_q     <= is_div & (div_zero | div_ovf);
            special_res_q <= special_res;
            dataE_q       <= stage_out(dataD, alu_result, 1'b0);
          end else begin
            dataE_q       <= stage_out(dataD, alu_result, dataD.valid);
          end
        end
        S_MUL_RUN: begin
          acc_q         <= acc_step;
          mcand_q       <= {mcand_q[126:0], 1'b0};
          mplier_q      <= {1'b0, mplier_q[63:1]};
          dataE_q.valid <= 1'b0;
          if (last_iter) state_q <= S_DONE;
          else           cnt_q   <= cnt_q + 7'd1;
        end
        S_DIV_RUN: begin
          rem_q         <= rem_step;
          quo_q         <= quo_step;
          dataE_q.valid <= 1'b0;
          if (last_iter) state_q <= S_DONE;
          else           cnt_q   <= cnt_q + 7'd1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= 7'd0;
          dataE_q <= stage_out(dataD, m_res, dataD.valid);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stope     = (state_q != S_IDLE) | m_op;
  assign dataE     = dataE_q;
  assign dbg_state = state_q;
  assign dbg_count = cnt_q;

endmodule
